fp_divider: RTL and testbench
=============================

FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst: clk is the rising-edge clock; rst, when high at a clk edge, resets all state regardless of ce.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 ce  input  1  clock enable; when low, all registers except under rst SHALL hold.
REQ-005 run  input  1  divide request; held high by the CPU while stall is high.
REQ-006 x  input  32  dividend (Oberon single: sign, 8-bit biased exponent, 23-bit fraction); SHALL be held stable while run is high.
REQ-007 y  input  32  divisor, same format and stability rule as x.
REQ-008 stall  output  1  high while a division is in progress.
REQ-009 z  output  32  registered quotient.

Function
REQ-010 Step counter S (5 bits): at a ce edge, S SHALL become 0 if run is low, hold at 27 if run is high and S=27, else increment.
REQ-011 stall SHALL equal run AND (S != 27): stall is high for exactly 27 cycles of ce, and low on the 28th.
REQ-012 At S=0 with run high, the block SHALL load remainder R (26 bits) with mx={1,x[22:0]} and clear quotient Q (26 bits).
REQ-013 Each of steps S=1..26 SHALL perform one restoring step against my={1,y[22:0]}: if R>=my, then R<=(R-my)<<1 and shift in 1; else R<=R<<1 and shift in 0. The result is Q=floor(mx*2^25/my).
REQ-014 Normalisation: if Q[25]=1, then mantissa Q[24:2], guard Q[1], e=xe-ye+127; otherwise mantissa Q[23:1], guard Q[0], e=xe-ye+126. e SHALL be computed signed, at least 10 bits wide.
REQ-015 sign SHALL be x[31] XOR y[31].
REQ-016 Special cases, in priority order:
- xe=0 gives z=0.
- ye=0 gives z={sign,8'hFF,23'b0}.
- final e>=255 gives {sign,8'hFF,23'b0}.
- final e<=0 gives 0.
- otherwise z={sign,e[7:0],mantissa}.
REQ-017 z SHALL be written only on the ce edge where S goes 26 to 27. It SHALL hold that value until the next completion or rst.
REQ-018 If run drops before S=27, S SHALL return to 0, the operation SHALL be abandoned, and z SHALL be unchanged.
REQ-019 With ce low, S, R, Q and z SHALL hold; stall SHALL still follow REQ-011 combinationally.
REQ-020 A new division SHALL start only from S=0; back-to-back operations require run low for at least one ce cycle.

Reset
REQ-021 On rst, S, R, Q and z SHALL be set to 0.
REQ-022 If rst is asserted mid-operation with run high, stall SHALL remain high and the operation SHALL restart at S=0 on the first edge after rst is released.

Configuration
REQ-023 With FP_DIV_ROUND_EN defined, the mantissa SHALL be incremented by the guard bit (round half-up). A carry out of bit 22 SHALL clear the mantissa and increment e before the range checks in REQ-016.
REQ-024 With FP_DIV_ROUND_EN undefined, the result SHALL be truncated (guard ignored), and latency is unchanged.

Structure
REQ-025 Shared package fp_pkg SHALL hold: FP_BIAS=127, FP_EXP_MAX=255, FP_FRAC_W=23, FP_DIV_STEPS=26, FP_DIV_DONE=27.
REQ-026 Normalise, round, special-case and pack logic SHALL sit in one combinational sub-module, fp_div_pack. The iteration datapath and counter stay in fp_divider.

Verification
REQ-027 1.0/1.0: x=0x3F800000, y=0x3F800000 -> stall high 27 cycles, then z=0x3F800000.
REQ-028 6.0/2.0: x=0x40C00000, y=0x40000000 -> z=0x40400000. Sign case: x=0xC0000000, y=0x3F800000 -> z=0xC0000000.
REQ-029 1/3: x=0x3F800000, y=0x40400000 -> z=0x3EAAAAAB with FP_DIV_ROUND_EN, 0x3EAAAAAA without it.
REQ-030 Zeros: y=0x00000000, x=0x40000000 -> z=0x7F800000. x=0x00000000, y=0x40000000 -> z=0x00000000.
REQ-031 Range: x=0x7F000000, y=0x00800000 -> z=0x7F800000. x=0x00800000, y=0x7F000000 -> z=0x00000000.
REQ-032 Control:
- rst pulsed at S=10 with run high -> stall stays high and completes 27 cycles after rst release.
- run dropped at S=10 -> S=0 and z unchanged.
- ce low for 5 cycles mid-operation -> latency grows by exactly 5.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and types for the Oberon-style single-precision divider.
// Optional feature macro: FP_DIV_ROUND_EN (round half-up on the guard bit).
package fp_pkg;

  localparam int FP_BIAS      = 127;
  localparam int FP_EXP_MAX   = 255;
  localparam int FP_FRAC_W    = 23;
  localparam int FP_DIV_STEPS = 26;
  localparam int FP_DIV_DONE  = 27;

  // Width of the step counter and of the remainder/quotient registers.
  localparam int STEP_W = 5;
  localparam int DIV_W  = 26;

  // Field view of a packed single.
  typedef struct packed {
    logic                 sign;
    logic [7:0]           exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp_t;

  // Signed infinity pattern used for divide-by-zero and overflow.
  function automatic logic [31:0] fp_inf(input logic sign);
    return {sign, 8'hFF, {FP_FRAC_W{1'b0}}};
  endfunction

endpackage

// File: rtl/fp_div_pack.sv
// Normalise, optionally round, apply special cases and pack the quotient.
// Purely combinational. Macro FP_DIV_ROUND_EN enables round half-up;
// without it the guard bit is discarded (truncation).
module fp_div_pack
  import fp_pkg::*;
(
  input  logic [DIV_W-1:0] q,
  input  logic [7:0]       x_exp,
  input  logic [7:0]       y_exp,
  input  logic             sign,
  output logic [31:0]      z
);

`ifdef FP_DIV_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  localparam logic signed [9:0] E_BIAS_HI = 10'(FP_BIAS);
  localparam logic signed [9:0] E_BIAS_LO = 10'(FP_BIAS - 1);
  localparam logic signed [9:0] E_MAX     = 10'(FP_EXP_MAX);

  logic [FP_FRAC_W-1:0] mant;
  logic [FP_FRAC_W-1:0] mant_fin;
  logic [FP_FRAC_W:0]   mant_inc;
  logic                 guard;
  logic signed [9:0]    e_raw;
  logic signed [9:0]    e_fin;

  // Pick the mantissa window by the quotient's leading bit, round, then pack.
  always_comb begin
    if (q[DIV_W-1]) begin
      mant  = q[24:2];
      guard = q[1];
      e_raw = $signed({2'b00, x_exp}) - $signed({2'b00, y_exp}) + E_BIAS_HI;
    end else begin
      mant  = q[23:1];
      guard = q[0];
      e_raw = $signed({2'b00, x_exp}) - $signed({2'b00, y_exp}) + E_BIAS_LO;
    end

    // A carry out of the fraction leaves the fraction at zero and bumps e.
    mant_inc = {1'b0, mant} + {{FP_FRAC_W{1'b0}}, guard & ROUND_EN};
    mant_fin = mant_inc[FP_FRAC_W-1:0];
    e_fin    = e_raw + (mant_inc[FP_FRAC_W] ? 10'sd1 : 10'sd0);

    if (x_exp == 8'd0) begin
      z = 32'd0;
    end else if (y_exp == 8'd0) begin
      z = fp_inf(sign);
    end else if (e_fin >= E_MAX) begin
      z = fp_inf(sign);
    end else if (e_fin <= 10'sd0) begin
      z = 32'd0;
    end else begin
      z = {sign, e_fin[7:0], mant_fin};
    end
  end

endmodule

// File: rtl/fp_divider.sv
// Sequential restoring divider for Oberon singles, one quotient bit per
// enabled cycle. stall = run & (step != 27). Handshake: the CPU raises run
// with stable x/y and keeps it high while stall is high; the result is in z
// in the cycle stall first reads low; run must drop for at least one enabled
// cycle before the next division. Macro FP_DIV_ROUND_EN selects rounding in
// fp_div_pack. s_dbg exposes the step counter.
module fp_divider
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              run,
  input  logic [31:0]       x,
  input  logic [31:0]       y,
  output logic              stall,
  output logic [31:0]       z,
  output logic [STEP_W-1:0] s_dbg
);

  localparam logic [STEP_W-1:0] S_DONE  = STEP_W'(FP_DIV_DONE);
  localparam logic [STEP_W-1:0] S_LAST  = STEP_W'(FP_DIV_STEPS);

  logic [STEP_W-1:0] s_q, s_d;
  logic [DIV_W-1:0]  r_q, r_d;
  logic [DIV_W-1:0]  q_q, q_d;
  logic [31:0]       z_q, z_d;

  logic [DIV_W-1:0]  mx_ext, my_ext;
  logic [DIV_W-1:0]  r_next, q_next;
  logic              r_ge;
  logic [31:0]       z_pack;

  assign mx_ext = {2'b00, 1'b1, x[22:0]};
  assign my_ext = {2'b00, 1'b1, y[22:0]};

  // One restoring step: trial subtract, keep the difference if non-negative.
  always_comb begin
    r_ge   = (r_q >= my_ext);
    r_next = r_ge ? ((r_q - my_ext) << 1) : (r_q << 1);
    q_next = {q_q[DIV_W-2:0], r_ge};
  end

  // Pack the quotient as it will stand after the final step.
  fp_div_pack u_pack (
    .q     (q_next),
    .x_exp (x[30:23]),
    .y_exp (y[30:23]),
    .sign  (x[31] ^ y[31]),
    .z     (z_pack)
  );

  // Counter advance, operand load, iteration and result capture.
  always_comb begin
    s_d = s_q;
    r_d = r_q;
    q_d = q_q;
    z_d = z_q;
    if (ce) begin
      if (!run) begin
        s_d = '0;
      end else if (s_q != S_DONE) begin
        s_d = s_q + STEP_W'(1);
      end

      if (run) begin
        if (s_q == '0) begin
          r_d = mx_ext;
          q_d = '0;
        end else if (s_q <= S_LAST) begin
          r_d = r_next;
          q_d = q_next;
          if (s_q == S_LAST) begin
            z_d = z_pack;
          end
        end
      end
    end
  end

  // State registers; reset overrides ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      r_q <= '0;
      q_q <= '0;
      z_q <= '0;
    end else begin
      s_q <= s_d;
      r_q <= r_d;
      q_q <= q_d;
      z_q <= z_d;
    end
  end

  assign stall = run & (s_q != S_DONE);
  assign z     = z_q;
  assign s_dbg = s_q;

endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider: directed vectors with literal results, plus an
// arithmetic reference model compared against stall, z and the step counter
// on every cycle.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        run;
  logic [31:0] x;
  logic [31:0] y;
  logic        stall;
  logic [31:0] z;
  logic [4:0]  s_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  fp_divider dut (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .run   (run),
    .x     (x),
    .y     (y),
    .stall (stall),
    .z     (z),
    .s_dbg (s_dbg)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference quotient: exact integer division of the significands, then
  // normalisation, optional half-up rounding and the range rules.
  function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
    int              xe;
    int              ye;
    int              e;
    int              mant;
    logic            sg;
    logic            g;
    longint unsigned mx;
    longint unsigned my;
    longint unsigned qv;
    xe = int'(a[30:23]);
    ye = int'(b[30:23]);
    sg = a[31] ^ b[31];
    if (xe == 0) return 32'd0;
    if (ye == 0) return {sg, 8'hFF, 23'd0};
    mx = 64'h800000 + 64'(a[22:0]);
    my = 64'h800000 + 64'(b[22:0]);
    qv = (mx << 25) / my;
    if (qv >= (64'd1 << 25)) begin
      mant = int'((qv >> 2) & 64'h7FFFFF);
      g    = qv[1];
      e    = xe - ye + 127;
    end else begin
      mant = int'((qv >> 1) & 64'h7FFFFF);
      g    = qv[0];
      e    = xe - ye + 126;
    end
`ifdef FP_DIV_ROUND_EN
    if (g) begin
      mant = mant + 1;
      if (mant == 32'h800000) begin
        mant = 0;
        e    = e + 1;
      end
    end
`else
    if (g) mant = mant;
`endif
    if (e >= 255) return {sg, 8'hFF, 23'd0};
    if (e <= 0) return 32'd0;
    return {sg, e[7:0], mant[22:0]};
  endfunction

  // Behavioural state: step count and last committed result.
  int          s_m = 0;
  logic [31:0] z_m = 32'd0;
  bit          armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      s_m = 0;
      z_m = 32'd0;
    end else if (ce) begin
      if (!run) begin
        s_m = 0;
      end else if (s_m != 27) begin
        if (s_m == 26) z_m = model_div(x, y);
        s_m = s_m + 1;
      end
    end
    armed = 1'b1;
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (armed) begin
      check("stall_cyc", {31'd0, stall}, {31'd0, (run && s_m != 27)});
      check("z_cyc", z, z_m);
      check("s_cyc", {27'd0, s_dbg}, 32'(s_m));
    end
  end

  // Drive one division; counts stall-high cycles. ce/rst/run disturbances are
  // applied in the cycle whose index (== step reached so far) matches.
  task automatic run_op(input logic [31:0] xv, input logic [31:0] yv,
                        input int ce_off_at, input int ce_off_len,
                        input int rst_at, input int drop_at, output int n);
    bit ended;
    x = xv;
    y = yv;
    run = 1'b1;
    n = 0;
    ended = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) begin
        ended = 1'b1;
        break;
      end
      n++;
      @(posedge clk);
      #1;
      ce  = !(n >= ce_off_at && n < ce_off_at + ce_off_len);
      rst = (n == rst_at);
      if (n == drop_at) run = 1'b0;
    end
    if (!ended) begin
      errors++;
      checks++;
      $display("FAIL timeout stall stuck high after %0d cycles", n);
    end
    if (exp_q.size() > 0) check("z_lit", z, exp_q.pop_front());
    @(posedge clk);
    #1;
    run = 1'b0;
    ce  = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic div_lit(input string name, input logic [31:0] xv, input logic [31:0] yv,
                         input logic [31:0] want);
    int n;
    exp_q.push_back(want);
    run_op(xv, yv, 1000, 0, 1000, 1000, n);
    check({name, "_lat"}, 32'(n), 32'd27);
  endtask

  initial begin
    int n;
    logic [31:0] third;
    rst = 1'b1;
    ce  = 1'b1;
    run = 1'b0;
    x   = 32'd0;
    y   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_z", z, 32'd0);
    check("rst_s", {27'd0, s_dbg}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Pin the model itself on hand-derived values.
    check("model_1_1", model_div(32'h3F800000, 32'h3F800000), 32'h3F800000);
    check("model_6_2", model_div(32'h40C00000, 32'h40000000), 32'h40400000);

`ifdef FP_DIV_ROUND_EN
    third = 32'h3EAAAAAB;
`else
    third = 32'h3EAAAAAA;
`endif

    div_lit("one_one",   32'h3F800000, 32'h3F800000, 32'h3F800000);
    div_lit("six_two",   32'h40C00000, 32'h40000000, 32'h40400000);
    div_lit("neg_two",   32'hC0000000, 32'h3F800000, 32'hC0000000);
    div_lit("one_third", 32'h3F800000, 32'h40400000, third);
    div_lit("div_zero",  32'h40000000, 32'h00000000, 32'h7F800000);
    div_lit("zero_div",  32'h00000000, 32'h40000000, 32'h00000000);
    div_lit("overflow",  32'h7F000000, 32'h00800000, 32'h7F800000);
    div_lit("underflow", 32'h00800000, 32'h7F000000, 32'h00000000);

    // Reset pulse at step 10 with run held: 11 cycles, then a full 27.
    div_lit("pre_rst", 32'h40C00000, 32'h40000000, 32'h40400000);
    exp_q.push_back(32'h40400000);
    run_op(32'h40C00000, 32'h40000000, 1000, 0, 10, 1000, n);
    check("rst_mid_lat", 32'(n), 32'd38);

    // Abandon at step 10: z keeps the previous result.
    exp_q.push_back(32'h40400000);
    run_op(32'h3F800000, 32'h40400000, 1000, 0, 1000, 10, n);
    check("drop_lat", 32'(n), 32'd10);
    check("drop_s", {27'd0, s_dbg}, 32'd0);

    // Five disabled cycles mid-operation stretch latency by five.
    exp_q.push_back(32'h3F800000);
    run_op(32'h3F800000, 32'h3F800000, 5, 5, 1000, 1000, n);
    check("ce_lat", 32'(n), 32'd32);

    // Further operands checked only through the reference model.
    run_op(32'h40490FDB, 32'h402DF854, 1000, 0, 1000, 1000, n);
    run_op(32'h3F7FFFFF, 32'h3F800001, 1000, 0, 1000, 1000, n);
    run_op(32'hBF800000, 32'hC0400000, 1000, 0, 1000, 1000, n);
    run_op(32'h3FFFFFFF, 32'h3F800001, 1000, 0, 1000, 1000, n);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
